// File: rtl/helper_axis_burst_scheduler.sv
// Gates a stream generator into fixed-length bursts separated by idle gaps,
// counting handshakes per burst and bursts per run.
module helper_axis_burst_scheduler #(
    parameter int BURST_LEN  = 4,
    parameter int GAP_CYCLES = 2,
    parameter int NUM_BURSTS = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 pause,
    output logic                 gen_enable,
    input  logic                 mon_valid,
    input  logic                 mon_ready,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] beat_count,
    output logic [CNT_WIDTH-1:0] burst_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BURST = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CNT_WIDTH-1:0] LP_BURST_LEN = CNT_WIDTH'(BURST_LEN);
    localparam logic [CNT_WIDTH-1:0] LP_NUM       = CNT_WIDTH'(NUM_BURSTS);
    // Only meaningful when GAP_CYCLES > 0; the GAP state is unreachable otherwise.
    localparam logic [CNT_WIDTH-1:0] LP_GAP_LAST  = CNT_WIDTH'(GAP_CYCLES - 1);

    logic [1:0]           r_state;
    logic [CNT_WIDTH-1:0] r_beat_cnt;
    logic [CNT_WIDTH-1:0] r_burst_cnt;
    logic [CNT_WIDTH-1:0] r_gap_cnt;

    logic                 w_beat;
    logic [CNT_WIDTH-1:0] w_beat_inc;
    logic [CNT_WIDTH-1:0] w_burst_inc;
    logic                 w_burst_end;
    logic                 w_run_end;

    assign gen_enable  = (r_state == S_BURST) & ~pause;
    assign w_beat      = gen_enable & mon_valid & mon_ready;
    assign w_beat_inc  = r_beat_cnt + 1'b1;
    assign w_burst_inc = r_burst_cnt + 1'b1;
    assign w_burst_end = w_beat & (w_beat_inc == LP_BURST_LEN);
    // An unbounded run never ends; burst_count simply wraps.
    assign w_run_end   = (NUM_BURSTS != 0) & (w_burst_inc == LP_NUM);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_beat_cnt  <= '0;
            r_burst_cnt <= '0;
            r_gap_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state     <= S_BURST;
                        r_beat_cnt  <= '0;
                        r_burst_cnt <= '0;
                        r_gap_cnt   <= '0;
                    end
                end
                S_BURST: begin
                    if (w_burst_end) begin
                        r_beat_cnt  <= '0;
                        r_burst_cnt <= w_burst_inc;
                        r_gap_cnt   <= '0;
                        if (w_run_end)
                            r_state <= S_DONE;
                        else if (GAP_CYCLES > 0)
                            r_state <= S_GAP;
                        else
                            r_state <= S_BURST;
                    end else if (w_beat) begin
                        r_beat_cnt <= w_beat_inc;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == LP_GAP_LAST) begin
                        r_gap_cnt <= '0;
                        r_state   <= S_BURST;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = (r_state == S_BURST) | (r_state == S_GAP);
    assign done        = (r_state == S_DONE);
    assign beat_count  = r_beat_cnt;
    assign burst_count = r_burst_cnt;

endmodule

// File: tb/tb_helper_axis_burst_scheduler.sv
// Bench for helper_axis_burst_scheduler: three parameterisations share stimulus and
// are each checked every cycle against a run-level model, plus a vector table and corner sequences.
module tb_helper_axis_burst_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, pause, mv, mr;

    logic        ge_a, busy_a, done_a;
    logic [15:0] beat_a, burst_a;
    logic        ge_b, busy_b, done_b;
    logic [15:0] beat_b, burst_b;
    logic        ge_c, busy_c, done_c;
    logic [2:0]  beat_c, burst_c;

    helper_axis_burst_scheduler u_a (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .gen_enable(ge_a),
        .mon_valid(mv), .mon_ready(mr), .busy(busy_a), .done(done_a),
        .beat_count(beat_a), .burst_count(burst_a));

    helper_axis_burst_scheduler #(.BURST_LEN(3), .GAP_CYCLES(0), .NUM_BURSTS(2)) u_b (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .gen_enable(ge_b),
        .mon_valid(mv), .mon_ready(mr), .busy(busy_b), .done(done_b),
        .beat_count(beat_b), .burst_count(burst_b));

    helper_axis_burst_scheduler #(.BURST_LEN(2), .GAP_CYCLES(1), .NUM_BURSTS(0), .CNT_WIDTH(3)) u_c (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .gen_enable(ge_c),
        .mon_valid(mv), .mon_ready(mr), .busy(busy_c), .done(done_c),
        .beat_count(beat_c), .burst_count(burst_c));

    int n_cmp = 0;
    int n_bad = 0;

    // Per-instance parameters as seen by the model
    int p_bl[3]  = '{4, 3, 2};
    int p_gap[3] = '{2, 0, 1};
    int p_num[3] = '{3, 2, 0};
    int p_w[3]   = '{16, 16, 3};

    // Model: a run is a count of beats since start; burst position is derived arithmetically.
    bit     m_act[3];
    bit     m_fin[3];
    longint m_tot[3];
    int     m_gap[3];

    // Activity recorders used by the hand-written sequences
    int          ge_cnt_a, ge_cnt_b, run_b, max_run_b, hidx;
    bit          hist_on;
    logic [29:0] hist;

    typedef struct {
        bit        st, pa, v, r;
        bit [34:0] exp;
    } vec_t;
    vec_t tbl[11];

    function automatic bit [34:0] pack(bit ge, bit bz, bit dn, longint bt, longint bu);
        bit [15:0] b1, b2;
        b1 = 16'(bt);
        b2 = 16'(bu);
        return {ge, bz, dn, b1, b2};
    endfunction

    function automatic bit [34:0] model_out(int d);
        longint bl, modv;
        bl   = longint'(p_bl[d]);
        modv = longint'(1) << p_w[d];
        return pack(m_act[d] && m_gap[d] == 0 && !pause, m_act[d], m_fin[d],
                    m_tot[d] % bl, (m_tot[d] / bl) % modv);
    endfunction

    function automatic logic [34:0] dut_out(int d);
        case (d)
            0:       return {ge_a, busy_a, done_a, beat_a, burst_a};
            1:       return {ge_b, busy_b, done_b, beat_b, burst_b};
            default: return {ge_c, busy_c, done_c, 13'd0, beat_c, 13'd0, burst_c};
        endcase
    endfunction

    task automatic cmp_vec(string name, logic [34:0] act, bit [34:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got ge/busy/done/beat/burst=%b/%b/%b/%0d/%0d, expected %b/%b/%b/%0d/%0d",
                     name, act[34], act[33], act[32], act[31:16], act[15:0],
                     exp[34], exp[33], exp[32], exp[31:16], exp[15:0]);
        end
    endtask

    task automatic cmp_val(string name, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                m_act[d] = 0; m_fin[d] = 0; m_tot[d] = 0; m_gap[d] = 0;
            end else if (!m_act[d]) begin
                if (start) begin
                    m_act[d] = 1; m_fin[d] = 0; m_tot[d] = 0; m_gap[d] = 0;
                end
            end else if (m_gap[d] > 0) begin
                m_gap[d]--;
            end else if (!pause && mv && mr) begin
                m_tot[d]++;
                if (m_tot[d] % p_bl[d] == 0) begin
                    if (p_num[d] != 0 && m_tot[d] / p_bl[d] == p_num[d]) begin
                        m_act[d] = 0; m_fin[d] = 1;
                    end else begin
                        m_gap[d] = p_gap[d];
                    end
                end
            end
        end
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic tick(bit chk, bit use_tbl, bit [34:0] tbl_exp, string tname);
        @(negedge clk);
        if (chk) begin
            cmp_vec("model_a", dut_out(0), model_out(0));
            cmp_vec("model_b", dut_out(1), model_out(1));
            cmp_vec("model_c", dut_out(2), model_out(2));
        end
        if (use_tbl) cmp_vec(tname, dut_out(0), tbl_exp);
        if (ge_a === 1'b1) ge_cnt_a++;
        if (ge_b === 1'b1) begin
            ge_cnt_b++;
            run_b++;
            if (run_b > max_run_b) max_run_b = run_b;
        end else begin
            run_b = 0;
        end
        if (hist_on && hidx < 30) begin
            hist[hidx] = ge_a;
            hidx++;
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) tick(1, 0, '0, "");
    endtask

    task automatic do_reset();
        rst = 1; start = 0; pause = 0;
        run(2);
        rst = 0;
        ge_cnt_a = 0; ge_cnt_b = 0; run_b = 0; max_run_b = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        run(1);
        start = 0;
    endtask

    initial begin
        bit exp_ge;

        tbl[0]  = '{1, 0, 1, 1, pack(0, 0, 0, 0, 0)};
        tbl[1]  = '{0, 0, 1, 1, pack(1, 1, 0, 0, 0)};
        tbl[2]  = '{0, 0, 1, 1, pack(1, 1, 0, 1, 0)};
        tbl[3]  = '{0, 0, 1, 1, pack(1, 1, 0, 2, 0)};
        tbl[4]  = '{0, 0, 1, 1, pack(1, 1, 0, 3, 0)};
        tbl[5]  = '{0, 0, 1, 1, pack(0, 1, 0, 0, 1)};
        tbl[6]  = '{0, 0, 1, 1, pack(0, 1, 0, 0, 1)};
        tbl[7]  = '{0, 1, 1, 1, pack(0, 1, 0, 0, 1)};
        tbl[8]  = '{0, 0, 1, 0, pack(1, 1, 0, 0, 1)};
        tbl[9]  = '{0, 0, 1, 1, pack(1, 1, 0, 0, 1)};
        tbl[10] = '{0, 0, 1, 1, pack(1, 1, 0, 1, 1)};

        rst = 1; start = 0; pause = 0; mv = 0; mr = 0;
        hist_on = 0; hidx = 0; hist = '0;
        for (int d = 0; d < 3; d++) begin
            m_act[d] = 0; m_fin[d] = 0; m_tot[d] = 0; m_gap[d] = 0;
        end
        tick(0, 0, '0, "");
        do_reset();

        // Vector table, first burst and a gap, with a pause and a stalled ready
        for (int i = 0; i < 11; i++) begin
            start = tbl[i].st; pause = tbl[i].pa; mv = tbl[i].v; mr = tbl[i].r;
            tick(1, 1, tbl[i].exp, $sformatf("table[%0d]", i));
        end
        start = 0; pause = 0;

        // Full default run with ready held high; B runs gapless, C wraps burst_count
        do_reset();
        mv = 1; mr = 1;
        pulse_start();
        ge_cnt_a = 0; ge_cnt_b = 0; run_b = 0; max_run_b = 0;
        hist_on = 1; hidx = 0;
        run(30);
        hist_on = 0;
        for (int i = 0; i < 30; i++) begin
            exp_ge = (i < 4) || (i >= 6 && i < 10) || (i >= 12 && i < 16);
            if (hist[i] !== exp_ge) begin
                n_bad++;
                $display("FAIL ge_pattern_a: cycle %0d got %b, expected %b", i, hist[i], exp_ge);
            end
        end
        n_cmp++;
        cmp_val("ge_total_a", ge_cnt_a, 12);
        cmp_val("done_a", done_a, 1);
        cmp_val("burst_a", burst_a, 3);
        cmp_val("ge_total_b", ge_cnt_b, 6);
        cmp_val("ge_run_b", max_run_b, 6);
        cmp_val("done_b", done_b, 1);
        cmp_val("burst_b", burst_b, 2);
        cmp_val("burst_c_wrap", burst_c, 2);

        // Ready toggling 1,0,1,0
        do_reset();
        mv = 1;
        mr = 1;
        pulse_start();
        for (int i = 0; i < 60; i++) begin
            mr = (i % 2 == 0);
            run(1);
        end
        mr = 1;
        cmp_val("toggle_burst_a", burst_a, 3);
        cmp_val("toggle_done_a", done_a, 1);

        // Pause after two beats of burst 0
        do_reset();
        mv = 1; mr = 1;
        pulse_start();
        run(2);
        pause = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            cmp_val("pause_ge_a", ge_a, 0);
            cmp_val("pause_beat_a", beat_a, 2);
            run(1);
        end
        pause = 0;
        run(2);
        cmp_val("pause_resume_burst_a", burst_a, 1);
        cmp_val("pause_resume_beat_a", beat_a, 0);

        // Reset in the gap after burst 0, then restart from zero
        do_reset();
        pulse_start();
        run(5);
        cmp_val("in_gap_busy_a", busy_a, 1);
        rst = 1;
        run(1);
        rst = 0;
        cmp_val("gap_rst_busy_a", busy_a, 0);
        cmp_val("gap_rst_burst_a", burst_a, 0);
        cmp_val("gap_rst_beat_a", beat_a, 0);
        pulse_start();
        run(4);
        cmp_val("restart_burst_a", burst_a, 1);

        // Reset wins over a simultaneous start
        rst = 1; start = 1;
        run(1);
        rst = 0; start = 0;
        cmp_val("rst_over_start_busy_a", busy_a, 0);

        // Start held while busy is ignored; start in DONE begins a clean run
        pulse_start();
        start = 1;
        run(10);
        start = 0;
        run(20);
        cmp_val("busy_start_done_a", done_a, 1);
        cmp_val("busy_start_burst_a", burst_a, 3);
        pulse_start();
        cmp_val("restart_busy_a", busy_a, 1);
        cmp_val("restart_cleared_a", burst_a, 0);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom % 300) == 0;
            start = ($urandom % 8) == 0;
            pause = ($urandom % 5) == 0;
            mv    = $urandom % 2;
            mr    = $urandom % 2;
            run(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
